// File: rtl/hsv_mode_apply.sv
// hsv_mode_apply
//   Applies the mode code from the button mode selector to the Hue/Saturation/Value registers.
//   It does this on every update tick and on every mode change. Each applied update is then
//   converted to 8-bit RGB in a three-stage pipeline for the PWM/LED driver.
//
// Parameters
//   TICK_DIV   clk cycles per update tick
//
// Ports
//   clk        in   1  system clock, all logic on posedge
//   reset      in   1  asynchronous, active-high reset
//   sost       in   4  mode code 0..6; 7..15 apply without changing anything
//   sw_h       in   9  switch hue request (mode 3), clamped to 359
//   sw_s       in   7  switch saturation request (mode 5), clamped to 100
//   sw_v       in   7  switch value request (mode 4), clamped to 100
//   hue        out  9  current hue 0..359
//   sat        out  7  current saturation 0..100
//   val        out  7  current value 0..100
//   rgb_r/g/b  out  8  converted colour, held between updates
//   rgb_valid  out  1  one-cycle pulse when rgb_* carry a freshly applied update
module hsv_mode_apply #(
  parameter int TICK_DIV = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sost,
  input  logic [8:0] sw_h,
  input  logic [6:0] sw_s,
  input  logic [6:0] sw_v,
  output logic [8:0] hue,
  output logic [6:0] sat,
  output logic [6:0] val,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b,
  output logic       rgb_valid
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    prev_sost;
  logic          tick;
  logic          mode_change;
  logic          apply_evt;

  assign tick        = (cnt == CNT_LAST);
  assign mode_change = (sost != prev_sost);
  assign apply_evt   = tick | mode_change;

  // Update-rate counter. A mode change restarts it, so the first periodic tick
  // after a change lands a full period later. A change and a tick arriving in
  // the same cycle collapse into one apply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      prev_sost <= 4'd0;
    end else begin
      prev_sost <= sost;
      if (apply_evt)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  logic [9:0] hue_sum60;
  logic [9:0] hue_sum1;
  logic [8:0] hue_n;
  logic [6:0] sat_n;
  logic [6:0] val_n;

  assign hue_sum60 = {1'b0, hue} + 10'd60;
  assign hue_sum1  = {1'b0, hue} + 10'd1;

  // Next H/S/V for the current mode. The sums are 10 bits wide so that wrap-around
  // past 359 can be detected and corrected by subtracting 360.
  always_comb begin
    hue_n = hue;
    sat_n = sat;
    val_n = val;
    case (sost)
      4'd0: hue_n = 9'd120;
      4'd1: hue_n = 9'((hue_sum60 >= 10'd360) ? (hue_sum60 - 10'd360) : hue_sum60);
      4'd2: hue_n = 9'((hue_sum1 >= 10'd360) ? (hue_sum1 - 10'd360) : hue_sum1);
      4'd3: hue_n = (sw_h > 9'd359) ? 9'd359 : sw_h;
      4'd4: val_n = (sw_v > 7'd100) ? 7'd100 : sw_v;
      5'd5: sat_n = (sw_s > 7'd100) ? 7'd100 : sw_s;
      4'd6: begin
        sat_n = 7'd50;
        val_n = 7'd50;
      end
      default: ;
    endcase
  end

  logic applied;

  // H/S/V registers. The 'applied' flag marks the cycle in which they were just
  // updated, and it starts the valid bit down the conversion pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hue     <= 9'd0;
      sat     <= 7'd100;
      val     <= 7'd100;
      applied <= 1'b0;
    end else begin
      applied <= apply_evt;
      if (apply_evt) begin
        hue <= hue_n;
        sat <= sat_n;
        val <= val_n;
      end
    end
  end

  // Stage 1: scale the value to 0..255 and split the hue into a 60-degree sector
  // and an offset within that sector.
  logic [14:0] vs_prod;
  logic [7:0]  vs_c;
  logic [2:0]  region_c;
  logic [8:0]  region_base;
  logic [5:0]  f_c;

  assign vs_prod = 15'(val) * 15'd255;
  assign vs_c    = 8'(vs_prod / 15'd100);

  always_comb begin
    region_c    = 3'd0;
    region_base = 9'd0;
    if (hue >= 9'd300) begin
      region_c    = 3'd5;
      region_base = 9'd300;
    end else if (hue >= 9'd240) begin
      region_c    = 3'd4;
      region_base = 9'd240;
    end else if (hue >= 9'd180) begin
      region_c    = 3'd3;
      region_base = 9'd180;
    end else if (hue >= 9'd120) begin
      region_c    = 3'd2;
      region_base = 9'd120;
    end else if (hue >= 9'd60) begin
      region_c    = 3'd1;
      region_base = 9'd60;
    end
  end

  assign f_c = 6'(hue - region_base);

  logic       s1_valid;
  logic [7:0] s1_vs;
  logic [2:0] s1_region;
  logic [5:0] s1_f;
  logic [6:0] s1_sat;

  // Stage 1 register. It loads every cycle and carries the valid bit with the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_vs     <= 8'd0;
      s1_region <= 3'd0;
      s1_f      <= 6'd0;
      s1_sat    <= 7'd0;
    end else begin
      s1_valid  <= applied;
      s1_vs     <= vs_c;
      s1_region <= region_c;
      s1_f      <= f_c;
      s1_sat    <= sat;
    end
  end

  // Stage 2: compute the p/q/t levels. Saturation is in percent and f is in degrees,
  // so q and t are scaled by 100*60 = 6000. The largest product, 255*6000, fits in 21 bits.
  logic [6:0]  sat_inv;
  logic [14:0] p_prod;
  logic [12:0] sat_f;
  logic [12:0] sat_fc;
  logic [20:0] q_prod;
  logic [20:0] t_prod;
  logic [7:0]  p_c;
  logic [7:0]  q_c;
  logic [7:0]  t_c;

  assign sat_inv = 7'd100 - s1_sat;
  assign p_prod  = 15'(s1_vs) * 15'(sat_inv);
  assign sat_f   = 13'(s1_sat) * 13'(s1_f);
  assign sat_fc  = 13'(s1_sat) * 13'(6'd60 - s1_f);
  assign q_prod  = 21'(s1_vs) * 21'(13'd6000 - sat_f);
  assign t_prod  = 21'(s1_vs) * 21'(13'd6000 - sat_fc);
  assign p_c     = 8'(p_prod / 15'd100);
  assign q_c     = 8'(q_prod / 21'd6000);
  assign t_c     = 8'(t_prod / 21'd6000);

  logic       s2_valid;
  logic [7:0] s2_vs;
  logic [2:0] s2_region;
  logic [7:0] s2_p;
  logic [7:0] s2_q;
  logic [7:0] s2_t;

  // Stage 2 register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_vs     <= 8'd0;
      s2_region <= 3'd0;
      s2_p      <= 8'd0;
      s2_q      <= 8'd0;
      s2_t      <= 8'd0;
    end else begin
      s2_valid  <= s1_valid;
      s2_vs     <= s1_vs;
      s2_region <= s1_region;
      s2_p      <= p_c;
      s2_q      <= q_c;
      s2_t      <= t_c;
    end
  end

  // Stage 3: route the levels to R/G/B according to the sector. The outputs change
  // only on a valid update, so the LED driver sees a steady colour between updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r     <= 8'd0;
      rgb_g     <= 8'd0;
      rgb_b     <= 8'd0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_valid <= s2_valid;
      if (s2_valid) begin
        case (s2_region)
          3'd0: begin rgb_r <= s2_vs; rgb_g <= s2_t;  rgb_b <= s2_p;  end
          3'd1: begin rgb_r <= s2_q;  rgb_g <= s2_vs; rgb_b <= s2_p;  end
          3'd2: begin rgb_r <= s2_p;  rgb_g <= s2_vs; rgb_b <= s2_t;  end
          3'd3: begin rgb_r <= s2_p;  rgb_g <= s2_q;  rgb_b <= s2_vs; end
          3'd4: begin rgb_r <= s2_t;  rgb_g <= s2_p;  rgb_b <= s2_vs; end
          default: begin rgb_r <= s2_vs; rgb_g <= s2_p; rgb_b <= s2_q; end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsv_mode_apply.sv
// tb_hsv_mode_apply
//   Directed self-checking bench for hsv_mode_apply with TICK_DIV=4.
//   Inputs change on the falling clock edge and outputs are sampled there too.
//   All expected colours are hand-computed from the integer HSV->RGB formulas.
module tb_hsv_mode_apply;

  logic       clk;
  logic       reset;
  logic [3:0] sost;
  logic [8:0] sw_h;
  logic [6:0] sw_s;
  logic [6:0] sw_v;
  logic [8:0] hue;
  logic [6:0] sat;
  logic [6:0] val;
  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;
  logic       rgb_valid;

  int checks_total;
  int checks_passed;
  int pulses;

  hsv_mode_apply #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sost      (sost),
    .sw_h      (sw_h),
    .sw_s      (sw_s),
    .sw_v      (sw_v),
    .hue       (hue),
    .sat       (sat),
    .val       (val),
    .rgb_r     (rgb_r),
    .rgb_g     (rgb_g),
    .rgb_b     (rgb_b),
    .rgb_valid (rgb_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks_total++;
    if (actual == expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive all mode inputs, then advance one clock.
  task automatic applyStimulus(input logic [3:0] mode, input logic [8:0] h,
                               input logic [6:0] s, input logic [6:0] v);
    sost = mode;
    sw_h = h;
    sw_s = s;
    sw_v = v;
    cycles(1);
  endtask

  task automatic checkRgb(input string tag, input int r, input int g, input int b);
    checkOutput({tag, ".valid"}, int'(rgb_valid), 1);
    checkOutput({tag, ".r"}, int'(rgb_r), r);
    checkOutput({tag, ".g"}, int'(rgb_g), g);
    checkOutput({tag, ".b"}, int'(rgb_b), b);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    pulses        = 0;
    reset = 1'b1;
    sost  = 4'd0;
    sw_h  = 9'd0;
    sw_s  = 7'd0;
    sw_v  = 7'd0;
    cycles(2);

    // T1: reset state, then the first periodic tick applies mode 0
    checkOutput("rst.hue", int'(hue), 0);
    checkOutput("rst.sat", int'(sat), 100);
    checkOutput("rst.val", int'(val), 100);
    checkOutput("rst.r", int'(rgb_r), 0);
    checkOutput("rst.g", int'(rgb_g), 0);
    checkOutput("rst.b", int'(rgb_b), 0);
    checkOutput("rst.valid", int'(rgb_valid), 0);
    reset = 1'b0;
    cycles(1);
    checkOutput("t1.hue_pre", int'(hue), 0);
    cycles(3);
    checkOutput("t1.hue", int'(hue), 120);
    checkOutput("t1.valid_early", int'(rgb_valid), 0);
    cycles(2);
    checkOutput("t1.valid_e6", int'(rgb_valid), 0);
    cycles(1);
    checkRgb("t1.rgb", 0, 255, 0);
    cycles(1);
    checkOutput("t1.valid_1cyc", int'(rgb_valid), 0);

    // T2: mode 6 gives half saturation and half value; Vs=127 exercises floor rounding
    applyStimulus(4'd6, 9'd0, 7'd0, 7'd0);
    checkOutput("t2.sat", int'(sat), 50);
    checkOutput("t2.val", int'(val), 50);
    checkOutput("t2.hue", int'(hue), 120);
    cycles(2);
    checkRgb("t2.prev_tick", 0, 255, 0);
    cycles(1);
    checkRgb("t2.rgb", 63, 127, 63);
    cycles(1);
    checkOutput("t2.valid_off", int'(rgb_valid), 0);

    // T3: hue wrap with mode 2 (+1) and mode 1 (+60)
    applyStimulus(4'd3, 9'd358, 7'd0, 7'd0);
    checkOutput("t3.hue358", int'(hue), 358);
    applyStimulus(4'd2, 9'd358, 7'd0, 7'd0);
    checkOutput("t3.hue359", int'(hue), 359);
    cycles(3);
    checkOutput("t3.hue_hold", int'(hue), 359);
    checkRgb("t3.rgb359", 127, 63, 64);
    cycles(1);
    checkOutput("t3.hue_wrap0", int'(hue), 0);
    cycles(4);
    checkOutput("t3.hue1", int'(hue), 1);
    applyStimulus(4'd3, 9'd330, 7'd0, 7'd0);
    checkOutput("t3.hue330", int'(hue), 330);
    applyStimulus(4'd1, 9'd330, 7'd0, 7'd0);
    checkOutput("t3.hue30", int'(hue), 30);
    cycles(3);
    checkRgb("t3.rgb30", 127, 95, 63);
    cycles(1);
    checkOutput("t3.hue90", int'(hue), 90);

    // T4: switch requests are clamped
    applyStimulus(4'd3, 9'd400, 7'd0, 7'd0);
    checkOutput("t4.hue_clamp", int'(hue), 359);
    applyStimulus(4'd4, 9'd400, 7'd0, 7'd127);
    checkOutput("t4.val_clamp", int'(val), 100);
    applyStimulus(4'd5, 9'd400, 7'd0, 7'd127);
    checkOutput("t4.sat0", int'(sat), 0);
    cycles(3);
    checkRgb("t4.grey", 255, 255, 255);
    applyStimulus(4'd9, 9'd400, 7'd0, 7'd127);
    checkOutput("t4.hold_sat", int'(sat), 0);
    applyStimulus(4'd5, 9'd400, 7'd100, 7'd127);
    checkOutput("t4.sat100", int'(sat), 100);
    cycles(3);
    checkRgb("t4.rgb_r5", 255, 0, 4);
    applyStimulus(4'd3, 9'd200, 7'd100, 7'd127);
    checkOutput("t4.hue200", int'(hue), 200);
    cycles(3);
    checkRgb("t4.rgb_r3", 0, 170, 255);

    // T5: hold mode still issues a pulse; a change coinciding with a tick applies once
    applyStimulus(4'd9, 9'd250, 7'd100, 7'd127);
    checkOutput("t5.hold_hue", int'(hue), 200);
    checkOutput("t5.hold_sat", int'(sat), 100);
    checkOutput("t5.hold_val", int'(val), 100);
    cycles(3);
    checkRgb("t5.hold_pulse", 0, 170, 255);
    applyStimulus(4'd2, 9'd250, 7'd100, 7'd127);
    checkOutput("t5.single_apply", int'(hue), 201);
    pulses = int'(rgb_valid);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      pulses += int'(rgb_valid);
    end
    checkOutput("t5.no_early_tick", int'(hue), 201);
    cycles(1);
    pulses += int'(rgb_valid);
    checkOutput("t5.tick_after_reload", int'(hue), 202);
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      pulses += int'(rgb_valid);
    end
    checkOutput("t5.pulse_count", pulses, 1);
    applyStimulus(4'd3, 9'd250, 7'd100, 7'd127);
    checkOutput("t5.hue250", int'(hue), 250);
    cycles(3);
    checkRgb("t5.rgb_r4", 42, 0, 255);

    // T6: reset one cycle after an apply discards the in-flight result
    applyStimulus(4'd0, 9'd250, 7'd100, 7'd127);
    checkOutput("t6.hue120", int'(hue), 120);
    reset = 1'b1;
    #1;
    checkOutput("t6.rst_hue", int'(hue), 0);
    checkOutput("t6.rst_sat", int'(sat), 100);
    checkOutput("t6.rst_val", int'(val), 100);
    checkOutput("t6.rst_r", int'(rgb_r), 0);
    checkOutput("t6.rst_valid", int'(rgb_valid), 0);
    cycles(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      checkOutput("t6.no_pulse", int'(rgb_valid), 0);
    end
    checkOutput("t6.g_zero", int'(rgb_g), 0);
    checkOutput("t6.b_zero", int'(rgb_b), 0);
    checkOutput("t6.hue_zero", int'(hue), 0);
    cycles(1);
    checkOutput("t6.resume_tick", int'(hue), 120);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
